// File: rtl/global_defs_pkg.sv
// Shared cache<->mem_ctrl definitions: request/address/data types plus mem_ctrl FSM types.
// BLOCK_DATA_WIDTH may be overridden on the command line; it defaults to one 64-bit block.
`ifndef BLOCK_DATA_WIDTH
`define BLOCK_DATA_WIDTH 64
`endif

package global_defs;

  localparam int MAIN_MEM_BLOCK_ADDR_WIDTH = 16;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } req_type_t;

  typedef logic [MAIN_MEM_BLOCK_ADDR_WIDTH-1:0] main_mem_block_addr_t;
  typedef logic [`BLOCK_DATA_WIDTH-1:0]          block_data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_ctrl_state_t;

  typedef enum logic {
    REQ_ICACHE = 1'b0,
    REQ_DCACHE = 1'b1
  } mem_requester_t;

  // 32-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_ctrl_main_mem_array.sv
// Behavioral single-port main memory: combinational read, synchronous write, no reset
// (contents survive a controller reset).
module main_mem_array #(
  parameter int N_BLOCKS = 1024,
  parameter int DATA_W   = 64,
  localparam int IDX_W   = $clog2(N_BLOCKS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [N_BLOCKS];

  // Write port: commit one block on the clock edge.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: responder side of the cache<->memory block protocol.
// One request in flight; icache has strict priority and a 1-entry pending slot so it is never
// stalled. Handshake: a request transfers on a rising edge where req_valid & req_ready are both 1;
// the response is a single-cycle resp_valid pulse with resp_block_data, which is 0 otherwise.
// Optional feature macro: MEM_CTRL_PERF_CNT_EN adds saturating accept counters.
module mem_ctrl
  import global_defs::*;
#(
  parameter int MEM_LATENCY       = 4,
  parameter int N_MAIN_MEM_BLOCKS = 1024
) (
  input  logic                 clk,
  input  logic                 rst_aL,
  input  logic                 icache_req_valid,
  input  req_type_t            icache_req_type,
  input  main_mem_block_addr_t icache_req_block_addr,
  output logic                 icache_req_ready,
  output logic                 icache_resp_valid,
  output block_data_t          icache_resp_block_data,
  input  logic                 dcache_req_valid,
  input  req_type_t            dcache_req_type,
  input  main_mem_block_addr_t dcache_req_block_addr,
  input  block_data_t          dcache_req_block_data,
  output logic                 dcache_req_ready,
  output logic                 dcache_resp_valid,
  output block_data_t          dcache_resp_block_data,
  output mem_ctrl_state_t      state_dbg
`ifdef MEM_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]          icache_req_cnt,
  output logic [31:0]          dcache_rd_cnt,
  output logic [31:0]          dcache_wr_cnt
`endif
);

  localparam int IDX_W = $clog2(N_MAIN_MEM_BLOCKS);
  localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;

  mem_ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  mem_requester_t       own_req_q;
  block_data_t          own_data_q;

  logic                 pend_valid_q;
  req_type_t            pend_type_q;
  main_mem_block_addr_t pend_addr_q;

  logic                 disp_valid;
  mem_requester_t       disp_owner;
  req_type_t            disp_type;
  main_mem_block_addr_t disp_addr;
  block_data_t          disp_data;

  logic                 mem_we;
  logic [IDX_W-1:0]     mem_idx;
  block_data_t          mem_rdata;

  logic                 ic_accept;
  logic                 dc_accept;
  logic                 ic_capture;

  assign icache_req_ready = ~pend_valid_q;
  assign dcache_req_ready = rst_aL & (state_q == IDLE) & ~pend_valid_q & ~icache_req_valid;
  assign ic_accept        = icache_req_valid & icache_req_ready;
  assign dc_accept        = dcache_req_valid & dcache_req_ready;
  assign ic_capture       = ic_accept & (state_q != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and dispatch selection: pending icache > live icache > dcache.
  always_comb begin
    state_d    = state_q;
    disp_valid = 1'b0;
    disp_owner = REQ_ICACHE;
    disp_type  = READ;
    disp_addr  = '0;
    disp_data  = '0;
    case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          disp_valid = 1'b1;
          disp_type  = pend_type_q;
          disp_addr  = pend_addr_q;
        end else if (icache_req_valid) begin
          disp_valid = 1'b1;
          disp_type  = icache_req_type;
          disp_addr  = icache_req_block_addr;
        end else if (dc_accept) begin
          disp_valid = 1'b1;
          disp_owner = REQ_DCACHE;
          disp_type  = dcache_req_type;
          disp_addr  = dcache_req_block_addr;
          disp_data  = dcache_req_block_data;
        end
        if (disp_valid) state_d = BUSY;
      end
      BUSY:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latency counter and owner register, loaded at dispatch and held until the response.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      cnt_q      <= '0;
      own_req_q  <= REQ_ICACHE;
      own_data_q <= '0;
    end else if (disp_valid) begin
      cnt_q      <= CNT_W'(MEM_LATENCY - 2);
      own_req_q  <= disp_owner;
      own_data_q <= (disp_type == WRITE) ? disp_data : mem_rdata;
    end else if (state_q == BUSY && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Pending icache slot: filled while busy, drained by the next IDLE dispatch.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      pend_valid_q <= 1'b0;
      pend_type_q  <= READ;
      pend_addr_q  <= '0;
    end else if (ic_capture) begin
      pend_valid_q <= 1'b1;
      pend_type_q  <= icache_req_type;
      pend_addr_q  <= icache_req_block_addr;
    end else if (state_q == IDLE && pend_valid_q) begin
      pend_valid_q <= 1'b0;
    end
  end

  // Upper address bits alias onto the memory depth.
  assign mem_idx = IDX_W'(disp_addr);
  assign mem_we  = disp_valid & (disp_type == WRITE);

  main_mem_array #(
    .N_BLOCKS (N_MAIN_MEM_BLOCKS),
    .DATA_W   ($bits(block_data_t))
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_idx),
    .wdata (disp_data),
    .rdata (mem_rdata)
  );

  assign icache_resp_valid      = (state_q == RESP) & (own_req_q == REQ_ICACHE);
  assign dcache_resp_valid      = (state_q == RESP) & (own_req_q == REQ_DCACHE);
  assign icache_resp_block_data = icache_resp_valid ? own_data_q : '0;
  assign dcache_resp_block_data = dcache_resp_valid ? own_data_q : '0;
  assign state_dbg              = state_q;

`ifdef MEM_CTRL_PERF_CNT_EN
  // Saturating accept counters.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      icache_req_cnt <= '0;
      dcache_rd_cnt  <= '0;
      dcache_wr_cnt  <= '0;
    end else begin
      if (ic_accept) icache_req_cnt <= sat_inc32(icache_req_cnt);
      if (dc_accept && dcache_req_type == READ)  dcache_rd_cnt <= sat_inc32(dcache_rd_cnt);
      if (dc_accept && dcache_req_type == WRITE) dcache_wr_cnt <= sat_inc32(dcache_wr_cnt);
    end
  end
`endif

  a_icache_never_stalled: assert property (@(posedge clk) disable iff (!rst_aL)
    !(icache_req_valid && !icache_req_ready))
    else $error("icache request presented while not ready");

  a_icache_read_only: assert property (@(posedge clk) disable iff (!rst_aL)
    icache_req_valid |-> icache_req_type == READ)
    else $error("icache issued a WRITE request");

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl (MEM_LATENCY=4). Inputs change on the falling edge; outputs are
// sampled 1 time unit later, so "cycle i" below is the i-th falling edge of a scenario.
module tb_mem_ctrl;
  import global_defs::*;

  localparam int LAT = 4;

  logic                 clk = 1'b0;
  logic                 rst_aL = 1'b0;
  logic                 ic_valid = 1'b0;
  req_type_t            ic_type = READ;
  main_mem_block_addr_t ic_addr = '0;
  logic                 icache_req_ready;
  logic                 icache_resp_valid;
  block_data_t          icache_resp_block_data;
  logic                 dc_valid = 1'b0;
  req_type_t            dc_type = READ;
  main_mem_block_addr_t dc_addr = '0;
  block_data_t          dc_data = '0;
  logic                 dcache_req_ready;
  logic                 dcache_resp_valid;
  block_data_t          dcache_resp_block_data;
  mem_ctrl_state_t      state_dbg;
`ifdef MEM_CTRL_PERF_CNT_EN
  logic [31:0] icache_req_cnt, dcache_rd_cnt, dcache_wr_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam block_data_t D10 = 64'hDEADBEEF_CAFEF00D;
  localparam block_data_t D20 = 64'h2020_0000_0000_0020;
  localparam block_data_t D21 = 64'h2121_1111_1111_0021;
  localparam block_data_t D30 = 64'h3030_A5A5_5A5A_0030;
  localparam block_data_t D31 = 64'h3131_0F0F_F0F0_0031;
  localparam block_data_t D40 = 64'h4040_1234_5678_0040;
  localparam block_data_t D41 = 64'h4141_8765_4321_0041;

  mem_ctrl #(.MEM_LATENCY(LAT), .N_MAIN_MEM_BLOCKS(1024)) dut (
    .clk                    (clk),
    .rst_aL                 (rst_aL),
    .icache_req_valid       (ic_valid),
    .icache_req_type        (ic_type),
    .icache_req_block_addr  (ic_addr),
    .icache_req_ready       (icache_req_ready),
    .icache_resp_valid      (icache_resp_valid),
    .icache_resp_block_data (icache_resp_block_data),
    .dcache_req_valid       (dc_valid),
    .dcache_req_type        (dc_type),
    .dcache_req_block_addr  (dc_addr),
    .dcache_req_block_data  (dc_data),
    .dcache_req_ready       (dcache_req_ready),
    .dcache_resp_valid      (dcache_resp_valid),
    .dcache_resp_block_data (dcache_resp_block_data),
    .state_dbg              (state_dbg)
`ifdef MEM_CTRL_PERF_CNT_EN
    ,
    .icache_req_cnt         (icache_req_cnt),
    .dcache_rd_cnt          (dcache_rd_cnt),
    .dcache_wr_cnt          (dcache_wr_cnt)
`endif
  );

  // Clock.
  always #5 clk = ~clk;

  // One complete transaction from IDLE: accept in cycle 0, single response pulse in cycle LAT.
  // Request inputs are scrambled after acceptance to show the controller holds its own copy.
  task automatic txn(input bit ic, input req_type_t t, input main_mem_block_addr_t a,
                     input block_data_t d, input block_data_t exp, input string nm);
    logic rdy, rv;
    block_data_t rd, exp_d;
    @(negedge clk);
    if (ic) begin ic_valid = 1'b1; ic_type = t; ic_addr = a; end
    else begin dc_valid = 1'b1; dc_type = t; dc_addr = a; dc_data = d; end
    #1;
    rdy = ic ? icache_req_ready : dcache_req_ready;
    vectors++;
    if (rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_accept: ready=%b expected 1", nm, rdy);
    end
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      ic_valid = 1'b0; dc_valid = 1'b0; ic_addr = '1; dc_addr = '1; dc_data = '1;
      #1;
      rv    = ic ? icache_resp_valid : dcache_resp_valid;
      rd    = ic ? icache_resp_block_data : dcache_resp_block_data;
      exp_d = (i == LAT) ? exp : '0;
      vectors++;
      if (rv !== (i == LAT) || rd !== exp_d) begin
        miscompares++;
        $display("FAIL %s_resp_c%0d: valid=%b data=%h expected valid=%b data=%h",
                 nm, i, rv, rd, (i == LAT), exp_d);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    vectors++;
    if (state_dbg !== IDLE || icache_resp_valid !== 1'b0 || dcache_resp_valid !== 1'b0 ||
        icache_resp_block_data !== '0 || dcache_resp_block_data !== '0 ||
        icache_req_ready !== 1'b1 || dcache_req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: st=%0d irv=%b drv=%b id=%h dd=%h irdy=%b drdy=%b expected 0 0 0 0 0 1 0",
               state_dbg, icache_resp_valid, dcache_resp_valid, icache_resp_block_data,
               dcache_resp_block_data, icache_req_ready, dcache_req_ready);
    end
    @(negedge clk);
    rst_aL = 1'b1;
    #1;
    vectors++;
    if (dcache_req_ready !== 1'b1 || icache_req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_ready: irdy=%b drdy=%b expected 1 1", icache_req_ready, dcache_req_ready);
    end
  endtask

  task automatic test_write_read();
    txn(1'b0, WRITE, 16'h0010, D10, D10, "dc_write_10");
    txn(1'b0, READ,  16'h0010, '0,  D10, "dc_read_10");
    txn(1'b0, READ,  16'h0410, '0,  D10, "dc_read_alias_410");
    txn(1'b0, WRITE, 16'h03FF, D31, D31, "dc_write_top");
    txn(1'b0, READ,  16'h03FF, '0,  D31, "dc_read_top");
  endtask

  task automatic test_priority();
    logic ei, ed;
    txn(1'b0, WRITE, 16'h0030, D30, D30, "prep_30");
    txn(1'b0, WRITE, 16'h0031, D31, D31, "prep_31");
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      ic_valid = (i == 0); ic_type = READ; ic_addr = 16'h0030;
      dc_valid = (i <= 5); dc_type = READ; dc_addr = 16'h0031;
      #1;
      if (i <= 5) begin
        vectors++;
        if (dcache_req_ready !== (i == 5)) begin
          miscompares++;
          $display("FAIL prio_dc_ready_c%0d: %b expected %b", i, dcache_req_ready, (i == 5));
        end
      end
      if (i == 0) begin
        vectors++;
        if (icache_req_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL prio_ic_ready: %b expected 1", icache_req_ready);
        end
      end
      ei = (i == 4); ed = (i == 9);
      vectors++;
      if (icache_resp_valid !== ei || dcache_resp_valid !== ed ||
          icache_resp_block_data !== (ei ? D30 : '0) || dcache_resp_block_data !== (ed ? D31 : '0)) begin
        miscompares++;
        $display("FAIL prio_resp_c%0d: iv=%b dv=%b id=%h dd=%h expected iv=%b dv=%b",
                 i, icache_resp_valid, dcache_resp_valid, icache_resp_block_data,
                 dcache_resp_block_data, ei, ed);
      end
    end
  endtask

  task automatic test_pending();
    logic ei, ed;
    block_data_t edd;
    txn(1'b0, WRITE, 16'h0040, D40, D40, "prep_40");
    txn(1'b0, WRITE, 16'h0041, D41, D41, "prep_41");
    for (int i = 0; i <= 14; i++) begin
      @(negedge clk);
      dc_valid = (i <= 10); dc_type = READ; dc_addr = (i == 0) ? 16'h0041 : 16'h0010;
      ic_valid = (i == 1);  ic_type = READ; ic_addr = 16'h0040;
      #1;
      if (i <= 10) begin
        vectors++;
        if (dcache_req_ready !== (i == 0 || i == 10)) begin
          miscompares++;
          $display("FAIL pend_dc_ready_c%0d: %b expected %b", i, dcache_req_ready, (i == 0 || i == 10));
        end
      end
      if (i == 1 || i == 2) begin
        vectors++;
        if (icache_req_ready !== (i == 1)) begin
          miscompares++;
          $display("FAIL pend_ic_ready_c%0d: %b expected %b", i, icache_req_ready, (i == 1));
        end
      end
      ei  = (i == 9);
      ed  = (i == 4 || i == 14);
      edd = (i == 4) ? D41 : (i == 14) ? D10 : '0;
      vectors++;
      if (icache_resp_valid !== ei || dcache_resp_valid !== ed ||
          icache_resp_block_data !== (ei ? D40 : '0) || dcache_resp_block_data !== edd) begin
        miscompares++;
        $display("FAIL pend_resp_c%0d: iv=%b dv=%b id=%h dd=%h expected iv=%b dv=%b dd=%h",
                 i, icache_resp_valid, dcache_resp_valid, icache_resp_block_data,
                 dcache_resp_block_data, ei, ed, edd);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic ei;
    block_data_t eid;
    txn(1'b0, WRITE, 16'h0020, D20, D20, "prep_20");
    txn(1'b0, WRITE, 16'h0021, D21, D21, "prep_21");
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      ic_valid = (i == 0 || i == 4); ic_type = READ; ic_addr = (i == 0) ? 16'h0020 : 16'h0021;
      dc_valid = 1'b0;
      #1;
      if (i == 4 || i == 5) begin
        vectors++;
        if (icache_req_ready !== (i == 4)) begin
          miscompares++;
          $display("FAIL b2b_ic_ready_c%0d: %b expected %b", i, icache_req_ready, (i == 4));
        end
      end
      ei  = (i == 4 || i == 9);
      eid = (i == 4) ? D20 : (i == 9) ? D21 : '0;
      vectors++;
      if (icache_resp_valid !== ei || icache_resp_block_data !== eid || dcache_resp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_resp_c%0d: iv=%b id=%h dv=%b expected iv=%b id=%h dv=0",
                 i, icache_resp_valid, icache_resp_block_data, dcache_resp_valid, ei, eid);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      dc_valid = (i == 0); dc_type = READ; dc_addr = 16'h0010;
      if (i == 2) rst_aL = 1'b0;
      if (i == 3) rst_aL = 1'b1;
      #1;
      if (i >= 1) begin
        vectors++;
        if (icache_resp_valid !== 1'b0 || dcache_resp_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL rst_busy_resp_c%0d: iv=%b dv=%b expected 0 0", i, icache_resp_valid, dcache_resp_valid);
        end
      end
      if (i == 3) begin
        vectors++;
        if (state_dbg !== IDLE) begin
          miscompares++;
          $display("FAIL rst_busy_state: %0d expected %0d", state_dbg, IDLE);
        end
      end
    end
    txn(1'b0, READ, 16'h0010, '0, D10, "rst_retained_10");
    txn(1'b1, READ, 16'h0040, '0, D40, "rst_retained_40");
  endtask

`ifdef MEM_CTRL_PERF_CNT_EN
  task automatic test_perf_cnt();
    @(negedge clk); rst_aL = 1'b0;
    @(negedge clk); rst_aL = 1'b1;
    txn(1'b1, READ,  16'h0020, '0,  D20, "perf_ic0");
    txn(1'b1, READ,  16'h0021, '0,  D21, "perf_ic1");
    txn(1'b1, READ,  16'h0030, '0,  D30, "perf_ic2");
    txn(1'b0, READ,  16'h0040, '0,  D40, "perf_dc0");
    txn(1'b0, READ,  16'h0041, '0,  D41, "perf_dc1");
    txn(1'b0, WRITE, 16'h0050, D10, D10, "perf_dw0");
    @(negedge clk); #1;
    vectors++;
    if (icache_req_cnt !== 32'd3 || dcache_rd_cnt !== 32'd2 || dcache_wr_cnt !== 32'd1) begin
      miscompares++;
      $display("FAIL perf_cnt: ic=%0d rd=%0d wr=%0d expected 3 2 1", icache_req_cnt, dcache_rd_cnt, dcache_wr_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_priority();
    test_pending();
    test_back_to_back();
    test_reset_mid_busy();
`ifdef MEM_CTRL_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
